// File: rtl/store_buffer_pkg.sv
// Shared drain-FSM encoding and address slicing constants for the store buffer.
package store_buffer_pkg;

   // Byte-offset bits dropped from every word address.
   localparam int WORD_LSB = 2;

   localparam logic [0:0] SB_IDLE = 1'b0;
   localparam logic [0:0] SB_REQ  = 1'b1;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match selector over the live buffer entries; purely combinational.
// Latency: 0 cycles. Backpressure: none; the result is valid every cycle.
module sb_fwd_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTRW  = 2,
   parameter int AW    = 30
) (
   input  logic [PTRW-1:0]            head,
   input  logic [PTRW:0]              count,
   input  logic [DEPTH-1:0][AW-1:0]   entry_addr,
   input  logic [AW-1:0]              load_addr,
   output logic                       hit,
   output logic [PTRW-1:0]            hit_idx
);

   // Walk oldest to youngest; a later match overrides so the youngest wins.
   // Pointer sums are PTRW bits wide, so wrap comes for free with power-of-two DEPTH.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (((PTRW+1)'(k) < count) && (entry_addr[head + PTRW'(k)] == load_addr)) begin
            hit     = 1'b1;
            hit_idx = head + PTRW'(k);
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// In-order posted-write buffer with youngest-store load forwarding.
// Latency: store to mem_req 1 cycle. Backpressure: Full stalls the core; drain waits on mem_ack.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int PTRW  = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemWrite,
   input  logic [WIDTH-1:0] DataAdr,
   input  logic [WIDTH-1:0] WriteData,
   output logic [WIDTH-1:0] ReadData,
   output logic             Full,
   output logic             Empty,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ack,
   output logic [WIDTH-1:0] mem_raddr,
   input  logic [WIDTH-1:0] mem_rdata
);

   localparam int AW = WIDTH - WORD_LSB;

   logic [DEPTH-1:0][AW-1:0]    ent_addr;
   logic [DEPTH-1:0][WIDTH-1:0] ent_dat;
   logic [PTRW-1:0]             head;
   logic [PTRW-1:0]             tail;
   logic [PTRW:0]               count;
   logic [PTRW:0]               count_nxt;
   logic [0:0]                  state;
   logic [0:0]                  state_nxt;
   logic                        enq;
   logic                        deq;
   logic                        fwd_hit;
   logic [PTRW-1:0]             fwd_idx;
   logic                        unused_lsb;

   assign unused_lsb = ^DataAdr[WORD_LSB-1:0];

   assign Full    = (count == (PTRW+1)'(DEPTH));
   assign Empty   = (count == '0);
   assign enq     = MemWrite && !Full;
   // count is never zero in SB_REQ, so an ack there always retires a real entry.
   assign deq     = (state == SB_REQ) && mem_ack;
   assign mem_req = (state == SB_REQ);

   always_comb begin
      count_nxt = count;
      if (enq && !deq) begin
         count_nxt = count + (PTRW+1)'(1);
      end else if (!enq && deq) begin
         count_nxt = count - (PTRW+1)'(1);
      end
   end

   // Deciding on the post-edge count lets a store into an empty buffer request next cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         SB_IDLE: if (count_nxt != '0) state_nxt = SB_REQ;
         SB_REQ:  if (count_nxt == '0) state_nxt = SB_IDLE;
         default: state_nxt = SB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= SB_IDLE;
      end else begin
         if (enq) begin
            tail <= tail + PTRW'(1);
         end
         if (deq) begin
            head <= head + PTRW'(1);
         end
         count <= count_nxt;
         state <= state_nxt;
      end
   end

   // Payload storage carries no reset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (enq) begin
         ent_addr[tail] <= DataAdr[WIDTH-1:WORD_LSB];
         ent_dat[tail]  <= WriteData;
      end
   end

   assign mem_addr  = {ent_addr[head], {WORD_LSB{1'b0}}};
   assign mem_wdata = ent_dat[head];
   assign mem_raddr = {DataAdr[WIDTH-1:WORD_LSB], {WORD_LSB{1'b0}}};

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .PTRW  (PTRW),
      .AW    (AW)
   ) u_fwd (
      .head       (head),
      .count      (count),
      .entry_addr (ent_addr),
      .load_addr  (DataAdr[WIDTH-1:WORD_LSB]),
      .hit        (fwd_hit),
      .hit_idx    (fwd_idx)
   );

   assign ReadData = fwd_hit ? ent_dat[fwd_idx] : mem_rdata;

endmodule
